serial_bit_feeder: RTL and testbench

Parallel-to-serial front end for the serial sequence FSM. It accepts WIDTH-bit words over a valid/ready handshake and shifts them out MSB-first, one bit per clock, on `x`. `x` drives the FSM's serial input directly. A one-entry holding register lets the next word queue during a shift, so back-to-back words stream with no idle cycle between them.

---
 rtl/serial_bit_feeder.sv | 174 +++++++++++++++++
 tb/tb_serial_bit_feeder.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/serial_bit_feeder.sv
// serial_bit_feeder
//   Parallel-to-serial front end. Accepts WIDTH-bit words on a valid/ready
//   handshake and emits them MSB-first, one bit per clock, on x. A one-entry
//   holding register queues the next word so consecutive frames stream with
//   no idle cycle between them.
//
//   Optional feature: define SER_PARITY_EN to append an even-parity bit
//   (XOR of the word) after the data bits. done then marks the parity bit.
//
// Ports
//   clk        in   rising-edge clock
//   rst        in   asynchronous, active-high reset
//   data_in    in   word to serialize, sampled on handshake
//   load_valid in   data_in valid
//   load_ready out  holding register empty
//   x          out  serial bit (0 when x_valid is low)
//   x_valid    out  x carries a frame bit
//   done       out  last bit of the frame is on x this cycle
//   busy       out  shifter or holding register occupied
module serial_bit_feeder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_in,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             x,
  output logic             x_valid,
  output logic             done,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH + 1);

`ifdef SER_PARITY_EN
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, PAR = 2'd2} state_t;
`else
  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;
`endif

  state_t           state, state_n;
  logic [WIDTH-1:0] sh, sh_n;       // bits still to be presented, MSB first
  logic [CW-1:0]    cnt, cnt_n;     // bits still to be presented
  logic [WIDTH-1:0] hold, hold_n;
  logic             hold_full, hold_full_n;
  logic             x_n, x_valid_n, done_n;
  logic             hs, direct;
  logic [WIDTH-1:0] src;
`ifdef SER_PARITY_EN
  logic             par, par_n;
`endif

  assign load_ready = !hold_full;
  assign hs         = load_valid && !hold_full;
  assign busy       = (state != IDLE) || hold_full;

  always_comb begin
    state_n     = state;
    sh_n        = sh;
    cnt_n       = cnt;
    hold_n      = hold;
    hold_full_n = hold_full;
    x_n         = x;
    x_valid_n   = x_valid;
    done_n      = 1'b0;
    direct      = 1'b0;
    src         = data_in;
`ifdef SER_PARITY_EN
    par_n       = par;
`endif
    case (state)
      IDLE: begin
        x_n       = 1'b0;
        x_valid_n = 1'b0;
        direct    = hs;
      end
      SHIFT: begin
        if (cnt == '0) begin
          // Tail cycle: the frame's last bit is on x. A queued word (or one
          // arriving now) starts at this edge so there is no gap.
          if (hold_full) begin
            direct      = 1'b1;
            src         = hold;
            hold_full_n = 1'b0;
          end else if (hs) begin
            direct = 1'b1;
          end else begin
            state_n   = IDLE;
            x_n       = 1'b0;
            x_valid_n = 1'b0;
          end
        end else begin
          x_n   = sh[WIDTH-1];
          sh_n  = {sh[WIDTH-2:0], 1'b0};
          cnt_n = cnt - CW'(1);
          if (cnt == CW'(1)) begin
`ifdef SER_PARITY_EN
            state_n = PAR;
`else
            done_n = 1'b1;
            // Reload with cnt=WIDTH: the next edge presents the new MSB.
            if (hold_full) begin
              sh_n        = hold;
              cnt_n       = CW'(WIDTH);
              hold_full_n = 1'b0;
            end
`endif
          end
        end
      end
`ifdef SER_PARITY_EN
      PAR: begin
        x_n     = par;
        done_n  = 1'b1;
        state_n = SHIFT;            // cnt is 0 here, so SHIFT means tail
        if (hold_full) begin
          sh_n        = hold;
          cnt_n       = CW'(WIDTH);
          hold_full_n = 1'b0;
          par_n       = ^hold;
        end
      end
`endif
      default: state_n = IDLE;
    endcase

    if (direct) begin
      sh_n      = {src[WIDTH-2:0], 1'b0};
      x_n       = src[WIDTH-1];
      x_valid_n = 1'b1;
      cnt_n     = CW'(WIDTH - 1);
      state_n   = SHIFT;
`ifdef SER_PARITY_EN
      par_n     = ^src;
`endif
    end

    // Word not taken by the shifter goes to the holding register.
    if (hs && !direct) begin
      hold_n      = data_in;
      hold_full_n = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      sh        <= '0;
      cnt       <= '0;
      hold      <= '0;
      hold_full <= 1'b0;
      x         <= 1'b0;
      x_valid   <= 1'b0;
      done      <= 1'b0;
`ifdef SER_PARITY_EN
      par       <= 1'b0;
`endif
    end else begin
      state     <= state_n;
      sh        <= sh_n;
      cnt       <= cnt_n;
      hold      <= hold_n;
      hold_full <= hold_full_n;
      x         <= x_n;
      x_valid   <= x_valid_n;
      done      <= done_n;
`ifdef SER_PARITY_EN
      par       <= par_n;
`endif
    end
  end

endmodule

// File: tb/tb_serial_bit_feeder.sv
// Testbench for serial_bit_feeder. Accepted words are turned into a timeline
// of expected serial bits (frame start = later of the handshake cycle and the
// end of the previous frame); a negedge monitor compares every cycle.
module tb_serial_bit_feeder;
  localparam int W = 8;
`ifdef SER_PARITY_EN
  localparam int F = W + 1;
`else
  localparam int F = W;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [W-1:0] data_in = '0;
  logic         load_valid = 1'b0;
  logic         load_ready, x, x_valid, done, busy;

  serial_bit_feeder #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .data_in(data_in), .load_valid(load_valid),
    .load_ready(load_ready), .x(x), .x_valid(x_valid), .done(done), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct { int c; bit b; bit last; } ent_t;
  ent_t exp_q[$];
  int   pk[$];   // handshake cycle of a word waiting in the holding register
  int   ps[$];   // its frame start cycle
  int   total = 0, bad = 0, cyc = 0, next_free = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] ex);
    total++;
    if (act !== ex) begin
      bad++;
      $display("FAIL %s cycle=%0d got=%0h want=%0h", nm, cyc, act, ex);
    end
  endtask

  task automatic push_word(input logic [W-1:0] w, input int k);
    int   s;
    ent_t e;
    s = (k > next_free) ? k : next_free;
    for (int i = 0; i < W; i++) begin
      e.c = s + i; e.b = w[W-1-i]; e.last = (i == F - 1);
      exp_q.push_back(e);
    end
`ifdef SER_PARITY_EN
    e.c = s + W; e.b = ^w; e.last = 1'b1;
    exp_q.push_back(e);
`endif
    next_free = s + F;
    if (s > k) begin pk.push_back(k); ps.push_back(s); end
  endtask

  // Handshake recorder: cycle index c = interval after the c-th rising edge.
  always @(posedge clk) begin
    cyc++;
    if (!rst && load_valid && load_ready) push_word(data_in, cyc);
  end

  always @(posedge rst) begin
    exp_q.delete(); pk.delete(); ps.delete(); next_free = 0;
  end

  always @(negedge clk) begin : mon
    int   c, lim;
    bit   ev, rdy;
    ent_t e;
    if (!rst) begin
      c = cyc;
      while (ps.size() > 0 && ps[0] <= c) begin
        void'(pk.pop_front()); void'(ps.pop_front());
      end
      // A queued word frees the holding register at the edge that presents
      // the previous frame's last bit, unless it arrived at that very edge.
      rdy = 1'b1;
      foreach (pk[i]) begin
        lim = (pk[i] > ps[i] - 2) ? pk[i] : ps[i] - 2;
        if (c >= pk[i] && c <= lim) rdy = 1'b0;
      end
      ev = (exp_q.size() > 0) && (exp_q[0].c == c);
      if (ev) begin
        e = exp_q.pop_front();
        chk("x_valid", x_valid, 1);
        chk("x", x, e.b);
        chk("done", done, e.last);
      end else begin
        chk("x_valid_idle", x_valid, 0);
        chk("x_idle", x, 0);
        chk("done_idle", done, 0);
      end
      chk("busy", busy, ev || (pk.size() > 0));
      chk("load_ready", load_ready, rdy);
    end
  end

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send(input logic [W-1:0] d);
    int n;
    n = 0;
    data_in = d; load_valid = 1'b1;
    while (!load_ready && n < 200) begin @(negedge clk); n++; end
    chk("ready_wait", load_ready, 1);
    @(negedge clk);
    load_valid = 1'b0;
    data_in = W'($urandom);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    logic [W-1:0] w;
    int n;
    // asynchronous reset with no clock edge
    #2 rst = 1'b1;
    #1;
    chk("rst_x", x, 0);
    chk("rst_x_valid", x_valid, 0);
    chk("rst_done", done, 0);
    chk("rst_load_ready", load_ready, 1);
    chk("rst_busy", busy, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    send(8'hB4); idle(12);

    send(8'hFF); send(8'h00);
    chk("ready_after_2nd", load_ready, 0);
    idle(20);

    send(8'h3C); send(8'hC3); send(8'h5A); idle(30);

`ifdef SER_PARITY_EN
    send(8'h07); idle(12);
`endif

    // reset during the 3rd bit of A5 with a word queued
    send(8'hA5); send(8'h66); @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("mrst_x", x, 0);
    chk("mrst_x_valid", x_valid, 0);
    chk("mrst_done", done, 0);
    chk("mrst_load_ready", load_ready, 1);
    chk("mrst_busy", busy, 0);
    repeat (2) begin
      @(posedge clk); #1;
      chk("mrst_done_hold", done, 0);
      chk("mrst_valid_hold", x_valid, 0);
    end
    @(negedge clk);
    rst = 1'b0;
    send(8'h96); idle(12);

    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 12));
      w = W'($urandom);
      send(w);
    end

    n = 0;
    while (exp_q.size() > 0 && n < 2000) begin @(negedge clk); n++; end
    chk("drain", exp_q.size(), 0);
    idle(3);
    chk("final_busy", busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
